l2_arbiter: RTL and testbench

Arbitrates line-sized miss traffic from the L1 instruction cache and L1 data cache onto the single CPU-side port of the L2 cache.
- Grants one requester at a time and latches its address and write data.
- Holds the L2 request until L2 responds, then routes the response back to the granted requester.
- Ties are broken round-robin.
- Sits directly upstream of the L2 cache controller and drives its mem_read/mem_write.

---
 rtl/cache_mux_types.sv | 21 ++
 rtl/rv32i_types.sv | 7 +
 rtl/perf_counter.sv | 36 +++
 rtl/l2_arbiter.sv | 163 ++++++++++++++++
 tb/tb_l2_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mux_types.sv
// Types shared by the L1-to-L2 muxing logic.
// Arbiter FSM states, grant identity and L2 op kind.
package cache_mux_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } grant_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } l2_op_t;

endpackage

// File: rtl/rv32i_types.sv
// Core-wide shared types and constants.
// Only what the cache/arbiter slice needs lives here.
package rv32i_types;

  localparam int perf_counter_width = 32;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter for performance monitoring.
// Holds at all-ones instead of wrapping.
module perf_counter
  import rv32i_types::*;
#(
  parameter int W = perf_counter_width
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: bump on event unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter of I/D L1 line misses onto the L2 CPU port.
// One transaction at a time; an IDLE cycle separates every grant.
module l2_arbiter
  import cache_mux_types::*;
  import rv32i_types::*;
#(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [s_addr-1:0] i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] wdata_q, wdata_d;
  l2_op_t            op_q, op_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic contention;

  logic [perf_counter_width-1:0] num_i_grants;
  logic [perf_counter_width-1:0] num_d_grants;
  logic [perf_counter_width-1:0] num_contention;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Grant decision, latching of the winner's request, FSM advance.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    contention   = 1'b0;
    unique case (state_q)
      IDLE: begin
        contention = i_req & d_req;
        if (i_req && (!d_req || last_grant_q == DATA)) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = INST;
          addr_d       = i_address;
        end
        if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = DATA;
          addr_d       = d_address;
          wdata_d      = d_wdata;
          op_d         = d_write ? OP_WRITE : OP_READ;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state and latched transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= INST;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= OP_READ;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
    end
  end

  // L2 request and L1 completion, purely from current state.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        l2_read = 1'b1;
        i_resp  = l2_resp;
      end
      SERVE_D: begin
        l2_read  = (op_q == OP_READ);
        l2_write = (op_q == OP_WRITE);
        d_resp   = l2_resp;
      end
      default: begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
      end
    endcase
  end

  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;

  perf_counter #(
    .W(perf_counter_width)
  ) u_num_i_grants (
    .clk  (clk),
    .rst  (rst),
    .inc  (grant_i),
    .count(num_i_grants)
  );

  perf_counter #(
    .W(perf_counter_width)
  ) u_num_d_grants (
    .clk  (clk),
    .rst  (rst),
    .inc  (grant_d),
    .count(num_d_grants)
  );

  perf_counter #(
    .W(perf_counter_width)
  ) u_num_contention (
    .clk  (clk),
    .rst  (rst),
    .inc  (contention),
    .count(num_contention)
  );

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized bench for l2_arbiter against a transaction-level model.
// Directed scenarios pin the model with literal expectations.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_address(l2_address),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_resp   (l2_resp)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_iresp = 0;
  int n_dresp = 0;

  // Model: who owns the L2 port (0 none, 1 I, 2 D) and who won last.
  int           m_own = 0;
  int           m_last = 1;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wd = '0;
  logic         m_wr = 1'b0;
  int           m_ni = 0;
  int           m_nd = 0;
  int           m_nc = 0;

  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] P1234 = {16{16'h1234}};

  task automatic chk(input string n, input logic [255:0] act,
                     input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    int w;
    w = 0;
    if (rst) begin
      m_own  <= 0;
      m_last <= 1;
      m_addr <= '0;
      m_wd   <= '0;
      m_wr   <= 1'b0;
      m_ni   <= 0;
      m_nd   <= 0;
      m_nc   <= 0;
    end else if (m_own != 0) begin
      if (l2_resp) m_own <= 0;
    end else begin
      if (i_read && (d_read || d_write)) begin
        m_nc <= m_nc + 1;
        w = (m_last == 1) ? 2 : 1;
      end else if (i_read) begin
        w = 1;
      end else if (d_read || d_write) begin
        w = 2;
      end
      if (w == 1) begin
        m_own  <= 1;
        m_last <= 1;
        m_addr <= i_address;
        m_ni   <= m_ni + 1;
      end else if (w == 2) begin
        m_own  <= 2;
        m_last <= 2;
        m_addr <= d_address;
        m_wd   <= d_wdata;
        m_wr   <= d_write;
        m_nd   <= m_nd + 1;
      end
    end
  end

  task automatic drive(input bit r, input bit ir, input bit dr,
                       input bit dw, input logic [31:0] ia,
                       input logic [31:0] da, input logic [255:0] wd,
                       input bit rs, input logic [255:0] rd);
    bit er, ew;
    @(negedge clk);
    rst = r;
    i_read = ir;
    d_read = dr;
    d_write = dw;
    i_address = ia;
    d_address = da;
    d_wdata = wd;
    l2_resp = rs;
    l2_rdata = rd;
    #1;
    er = (m_own == 1) || (m_own == 2 && !m_wr);
    ew = (m_own == 2) && m_wr;
    chk("l2_read", l2_read, er);
    chk("l2_write", l2_write, ew);
    chk("l2_address", l2_address, m_addr);
    chk("l2_wdata", l2_wdata, m_wd);
    chk("i_resp", i_resp, (m_own == 1) && rs);
    chk("d_resp", d_resp, (m_own == 2) && rs);
    chk("i_rdata", i_rdata, rd);
    chk("d_rdata", d_rdata, rd);
    chk("num_i_grants", dut.num_i_grants, m_ni);
    chk("num_d_grants", dut.num_d_grants, m_nd);
    chk("num_contention", dut.num_contention, m_nc);
    if (i_resp) n_iresp++;
    if (d_resp) n_dresp++;
  endtask

  task automatic idle1(input bit rs);
    drive(0, 0, 0, 0, 32'h0, 32'h0, '0, rs, '0);
  endtask

  initial begin
    int p;
    int who;
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    l2_resp = 0; l2_rdata = '0;
    @(posedge clk);
    drive(1, 0, 0, 0, 0, 0, '0, 0, '0);
    idle1(0);
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_l2_address", l2_address, 0);
    chk("rst_l2_wdata", l2_wdata, 0);

    // Isolated I read, L2 answers 3 cycles after l2_read rises.
    p = n_iresp;
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    chk("t_i_idle", l2_read, 0);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    chk("t_i_read", l2_read, 1);
    chk("t_i_addr", l2_address, 32'h1040);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 1, A5);
    chk("t_i_resp", i_resp, 1);
    chk("t_i_rdata", i_rdata, A5);
    chk("t_i_dresp", d_resp, 0);
    idle1(0);
    chk("t_i_pulses", n_iresp - p, 1);

    // Isolated D write with d_wdata scrambled while waiting.
    p = n_dresp;
    drive(0, 0, 0, 1, 0, 32'h2000, P1234, 0, '0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 0, 32'h2000, ~P1234, 0, '0);
      chk("t_d_write", l2_write, 1);
      chk("t_d_read", l2_read, 0);
      chk("t_d_wdata", l2_wdata, P1234);
    end
    drive(0, 0, 0, 1, 0, 32'h2000, ~P1234, 1, '0);
    chk("t_d_resp", d_resp, 1);
    idle1(0);
    chk("t_d_pulses", n_dresp - p, 1);

    // Simultaneous requests right after reset: D wins first.
    drive(1, 0, 0, 0, 0, 0, '0, 0, '0);
    drive(0, 1, 1, 0, 32'h1040, 32'h2000, '0, 0, '0);
    drive(0, 1, 1, 0, 32'h1040, 32'h2000, '0, 0, '0);
    chk("t_s_first", l2_address, 32'h2000);
    drive(0, 1, 1, 0, 32'h1040, 32'h2000, '0, 1, '0);
    chk("t_s_dresp", d_resp, 1);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    chk("t_s_gap", l2_read, 0);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 1, '0);
    chk("t_s_second", l2_address, 32'h1040);
    chk("t_s_iresp", i_resp, 1);
    idle1(0);
    chk("t_s_nc", dut.num_contention, 1);
    chk("t_s_nd", dut.num_d_grants, 1);
    chk("t_s_ni", dut.num_i_grants, 1);

    // Both held high: grants alternate D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 0, 32'h40, 32'h80, '0, 0, '0);
      chk("t_f_idle", l2_read | l2_write, 0);
      drive(0, 1, 1, 0, 32'h40, 32'h80, '0, 1, '0);
      who = d_resp ? 2 : (i_resp ? 1 : 0);
      chk("t_f_order", who, (k % 2 == 0) ? 2 : 1);
    end
    idle1(0);

    // Reset while waiting on L2 abandons the I read.
    p = n_iresp;
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    drive(0, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    chk("t_r_busy", l2_read, 1);
    drive(1, 1, 0, 0, 32'h1040, 0, '0, 0, '0);
    idle1(1);
    chk("t_r_read", l2_read, 0);
    chk("t_r_iresp", i_resp, 0);
    chk("t_r_addr", l2_address, 0);
    drive(0, 1, 0, 0, 32'h3000, 0, '0, 0, '0);
    drive(0, 1, 0, 0, 32'h3000, 0, '0, 1, '0);
    chk("t_r_fresh", l2_address, 32'h3000);
    chk("t_r_fresh_resp", i_resp, 1);
    chk("t_r_pulses", n_iresp - p, 1);

    // Stray response in IDLE.
    idle1(0);
    idle1(1);
    chk("t_x_iresp", i_resp, 0);
    chk("t_x_dresp", d_resp, 0);
    idle1(0);
    chk("t_x_idle", l2_read | l2_write, 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom, $urandom,
            {8{$urandom}},
            $urandom_range(0, 2) == 0,
            {8{$urandom}});
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
